// File: rtl/tlul_err_resp.sv
// rtl/tlul_err_resp.sv - TL-UL error responder: queues requests and answers each with d_error=1
// Optional error counter enabled by defining TLUL_ERR_RESP_CNT_EN.

package tlul_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;

  // D-channel opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_err_resp
  import tlul_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  tl_h2d_t       tl_i,
`ifdef TLUL_ERR_RESP_CNT_EN
  input  logic          err_cnt_clr_i,
  output logic [15:0]   err_cnt_o,
`endif
  output tl_d2h_t       tl_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic       is_get;
    logic [1:0] size;
    logic [7:0] source;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   full, empty;
  logic   a_fire, d_fire;
  entry_t head;
  entry_t wr_entry;

  // Address, mask, data and param never influence the error response.
  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address, tl_i.a_mask, tl_i.a_data};

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign a_fire = tl_i.a_valid & ~full;
  assign d_fire = ~empty & tl_i.d_ready;
  assign head   = mem_q[rd_ptr_q];

  // Only a Get earns AccessAckData; every other opcode, legal or not, gets AccessAck.
  always_comb begin
    wr_entry        = '0;
    wr_entry.is_get = (tl_i.a_opcode == GET);
    wr_entry.size   = tl_i.a_size;
    wr_entry.source = tl_i.a_source;
  end

  // Pointer and occupancy next-state; both pointers wrap at DEPTH-1.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (a_fire) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (d_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (a_fire && !d_fire) begin
      count_d = count_q + 1'b1;
    end else if (d_fire && !a_fire) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers; reset discards every queued entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at wr_ptr on every accepted request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (a_fire) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Response drive: purely from registered state, zeroed while the queue is empty.
  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = ~full;
    if (!empty) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_error  = 1'b1;
      tl_o.d_opcode = head.is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      tl_o.d_size   = head.size;
      tl_o.d_source = head.source;
      tl_o.d_data   = head.is_get ? ERR_DATA : 32'h0;
    end
  end

`ifdef TLUL_ERR_RESP_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating response counter; clear has priority over increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr_i) begin
      err_cnt_d = '0;
    end else if (d_fire && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_tlul_err_resp.sv
// tb/tb_tlul_err_resp.sv - directed bench with response scoreboard for tlul_err_resp

module tb_tlul_err_resp;
  import tlul_pkg::*;

  logic    clk_i;
  logic    rst_i;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
`ifdef TLUL_ERR_RESP_CNT_EN
  logic        err_cnt_clr_i;
  logic [15:0] err_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  tlul_err_resp #(.DEPTH(2), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tl_i          (tl_i),
`ifdef TLUL_ERR_RESP_CNT_EN
    .err_cnt_clr_i (err_cnt_clr_i),
    .err_cnt_o     (err_cnt_o),
`endif
    .tl_o          (tl_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  // Scoreboard: push on accepted request, compare head while d_valid, pop on d_fire.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      sbq.delete();
    end else begin
      if (tl_o.d_valid) begin
        chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq[0];
          chk("sb_opcode", 32'(tl_o.d_opcode), 32'(e.op));
          chk("sb_size",   32'(tl_o.d_size),   32'(e.size));
          chk("sb_source", 32'(tl_o.d_source), 32'(e.source));
          chk("sb_data",   tl_o.d_data,        e.data);
          chk("sb_error",  32'(tl_o.d_error),  32'd1);
          if (tl_i.d_ready) void'(sbq.pop_front());
        end
      end
      if (tl_i.a_valid && tl_o.a_ready) begin
        e.op     = (tl_i.a_opcode == 3'h4) ? 3'h1 : 3'h0;
        e.size   = tl_i.a_size;
        e.source = tl_i.a_source;
        e.data   = (tl_i.a_opcode == 3'h4) ? 32'hFFFF_FFFF : 32'h0;
        sbq.push_back(e);
      end
    end
  end

  initial begin
    tl_i  = '0;
    rst_i = 1'b0;
`ifdef TLUL_ERR_RESP_CNT_EN
    err_cnt_clr_i = 1'b0;
`endif

    // 1. Reset: outputs take reset values at once.
    #2 rst_i = 1'b1;
    #1;
    chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    chk("rst_d_error", 32'(tl_o.d_error), 32'd0);
    chk("rst_d_data",  tl_o.d_data,       32'd0);
`ifdef TLUL_ERR_RESP_CNT_EN
    chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
`endif
    #20 rst_i = 1'b0;

    // 1b. Reset mid-operation discards a queued entry.
    cyc();
    tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'h4; tl_i.a_size = 2'd2; tl_i.a_source = 8'd9;
    tl_i.d_ready = 1'b0;
    cyc();
    tl_i.a_valid = 1'b0;
    mid();
    chk("pre_rst_d_valid", 32'(tl_o.d_valid), 32'd1);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("async_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("async_rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    mid();
    #2 rst_i = 1'b0;
    mid();
    chk("post_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("post_rst_a_ready", 32'(tl_o.a_ready), 32'd1);

    // 2. Single Get.
    cyc();
    tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'h4; tl_i.a_size = 2'd2; tl_i.a_source = 8'd5;
    tl_i.d_ready = 1'b1;
    mid();
    chk("get_no_bypass", 32'(tl_o.d_valid), 32'd0);
    cyc();
    tl_i.a_valid = 1'b0;
    mid();
    chk("get_d_valid",  32'(tl_o.d_valid),  32'd1);
    chk("get_d_opcode", 32'(tl_o.d_opcode), 32'd1);
    chk("get_d_data",   tl_o.d_data,        32'hFFFF_FFFF);
    chk("get_d_size",   32'(tl_o.d_size),   32'd2);
    chk("get_d_source", 32'(tl_o.d_source), 32'd5);
    chk("get_d_error",  32'(tl_o.d_error),  32'd1);
    cyc();
    mid();
    chk("get_done", 32'(tl_o.d_valid), 32'd0);

    // 3. PutFullData.
    cyc();
    tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'h0; tl_i.a_size = 2'd1; tl_i.a_source = 8'd3;
    cyc();
    tl_i.a_valid = 1'b0;
    mid();
    chk("put_d_opcode", 32'(tl_o.d_opcode), 32'd0);
    chk("put_d_data",   tl_o.d_data,        32'd0);
    chk("put_d_source", 32'(tl_o.d_source), 32'd3);
    chk("put_d_size",   32'(tl_o.d_size),   32'd1);
    chk("put_d_error",  32'(tl_o.d_error),  32'd1);
    cyc();

    // 4. Backpressure fills the queue; responses drain in order.
    tl_i.d_ready = 1'b0;
    tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'h4; tl_i.a_size = 2'd2; tl_i.a_source = 8'd1;
    mid();
    chk("bp_a_ready_0", 32'(tl_o.a_ready), 32'd1);
    cyc();
    tl_i.a_source = 8'd2;
    mid();
    chk("bp_a_ready_1", 32'(tl_o.a_ready), 32'd1);
    cyc();
    tl_i.a_source = 8'd3;
    mid();
    chk("bp_full_a_ready", 32'(tl_o.a_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      mid();
      chk("bp_stall_source", 32'(tl_o.d_source), 32'd1);
      chk("bp_stall_a_ready", 32'(tl_o.a_ready), 32'd0);
    end
    cyc();
    tl_i.d_ready = 1'b1;
    cyc();
    mid();
    chk("bp_resp2_source", 32'(tl_o.d_source), 32'd2);
    chk("bp_resp2_a_ready", 32'(tl_o.a_ready), 32'd1);
    cyc();
    tl_i.a_valid = 1'b0;
    mid();
    chk("bp_resp3_source", 32'(tl_o.d_source), 32'd3);
    cyc();
    mid();
    chk("bp_drained", 32'(tl_o.d_valid), 32'd0);

    // 5. Simultaneous fire holds occupancy at one.
    cyc();
    tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'h0; tl_i.a_size = 2'd0; tl_i.a_source = 8'd0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i < 10) tl_i.a_source = 8'(i);
      else        tl_i.a_valid  = 1'b0;
      mid();
      chk("sim_d_valid", 32'(tl_o.d_valid),  32'd1);
      chk("sim_a_ready", 32'(tl_o.a_ready),  32'd1);
      chk("sim_source",  32'(tl_o.d_source), 32'(i - 1));
    end
    cyc();
    mid();
    chk("sim_drained", 32'(tl_o.d_valid), 32'd0);

    // 6. Illegal opcode answered with AccessAck.
    cyc();
    tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'h7; tl_i.a_size = 2'd3; tl_i.a_source = 8'hAA;
    cyc();
    tl_i.a_valid = 1'b0;
    mid();
    chk("ill_d_opcode", 32'(tl_o.d_opcode), 32'd0);
    chk("ill_d_error",  32'(tl_o.d_error),  32'd1);
    chk("ill_d_data",   tl_o.d_data,        32'd0);
    cyc();

`ifdef TLUL_ERR_RESP_CNT_EN
    // Responses since the last reset: 1 + 1 + 3 + 10 + 1.
    mid();
    chk("cnt_after_directed", 32'(err_cnt_o), 32'd16);
    cyc();
    tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'h0; tl_i.a_size = 2'd0;
    for (int i = 0; i < 70000; i++) begin
      cyc();
      tl_i.a_source = i[7:0];
    end
    mid();
    chk("cnt_saturated", 32'(err_cnt_o), 32'hFFFF);
    cyc();
    err_cnt_clr_i = 1'b1;
    cyc();
    err_cnt_clr_i = 1'b0;
    mid();
    chk("cnt_cleared", 32'(err_cnt_o), 32'd0);
    cyc();
    mid();
    chk("cnt_after_clear", 32'(err_cnt_o), 32'd1);
    tl_i.a_valid = 1'b0;
    cyc();
    cyc();
    mid();
    chk("cnt_drained", 32'(tl_o.d_valid), 32'd0);
`endif

    chk("sb_empty_at_end", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
